// File: rtl/imem_readback.sv
// Instruction-memory dump engine: reads a word range from IMEM and streams each word
// little-endian over an 8N1 UART transmitter, with range checking and byte-boundary abort.
module imem_readback #(
   parameter int unsigned BAUD_RATE  = 115200,
   parameter int unsigned CLK_FREQ   = 100_000_000,
   parameter int unsigned IMEM_DEPTH = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [9:0]  start_addr,
   input  logic [10:0] word_count,
   output logic        imem_rd_en,
   output logic [9:0]  imem_rd_addr,
   input  logic [31:0] imem_rd_data,
   output logic        uart_tx,
   output logic        busy,
   output logic        dump_done,
   output logic        dump_error
);

   localparam int unsigned ClksPerBit = CLK_FREQ / BAUD_RATE;
   localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);
   localparam logic [11:0] DepthW      = 12'(IMEM_DEPTH);

   typedef enum logic [2:0] {StIdle, StFetch, StLatch, StSend, StNext} state_e;

   state_e          state_q;
   logic [CntW-1:0] clk_cnt_q;
   logic [3:0]      bit_idx_q;   // 0 = start bit, 1..8 = data, 9 = stop bit
   logic [1:0]      byte_idx_q;
   logic [10:0]     remaining_q;
   logic [31:0]     shreg_q;
   logic            abort_q;

   logic [11:0] range_end;
   logic        abort_hit;

   assign range_end = {2'b00, start_addr} + {1'b0, word_count};
   assign abort_hit = abort_q | abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         clk_cnt_q    <= '0;
         bit_idx_q    <= '0;
         byte_idx_q   <= '0;
         remaining_q  <= '0;
         shreg_q      <= '0;
         abort_q      <= 1'b0;
         imem_rd_en   <= 1'b0;
         imem_rd_addr <= '0;
         uart_tx      <= 1'b1;
         busy         <= 1'b0;
         dump_done    <= 1'b0;
         dump_error   <= 1'b0;
      end else begin
         if (busy && abort) abort_q <= 1'b1;

         unique case (state_q)
            StIdle: begin
               if (start && !abort) begin
                  dump_done  <= 1'b0;
                  dump_error <= 1'b0;
                  if (range_end > DepthW) begin
                     dump_error <= 1'b1;
                  end else if (word_count == 11'd0) begin
                     dump_done <= 1'b1;
                  end else begin
                     imem_rd_addr <= start_addr;
                     remaining_q  <= word_count;
                     busy         <= 1'b1;
                     imem_rd_en   <= 1'b1;
                     state_q      <= StFetch;
                  end
               end
            end

            StFetch: begin
               imem_rd_en <= 1'b0;
               if (abort_hit) begin
                  state_q <= StIdle;
                  busy    <= 1'b0;
                  abort_q <= 1'b0;
               end else begin
                  state_q <= StLatch;
               end
            end

            StLatch: begin
               if (abort_hit) begin
                  state_q <= StIdle;
                  busy    <= 1'b0;
                  abort_q <= 1'b0;
               end else begin
                  shreg_q    <= imem_rd_data;
                  uart_tx    <= 1'b0;
                  clk_cnt_q  <= '0;
                  bit_idx_q  <= '0;
                  byte_idx_q <= '0;
                  state_q    <= StSend;
               end
            end

            StSend: begin
               if (clk_cnt_q != CntLast) begin
                  clk_cnt_q <= clk_cnt_q + CntW'(1);
               end else begin
                  clk_cnt_q <= '0;
                  if (bit_idx_q == 4'd9) begin
                     // Byte boundary: the only place a pending abort may take effect.
                     if (abort_hit) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        abort_q <= 1'b0;
                     end else if (byte_idx_q == 2'd3) begin
                        state_q <= StNext;
                     end else begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        bit_idx_q  <= 4'd0;
                        uart_tx    <= 1'b0;
                     end
                  end else begin
                     bit_idx_q <= bit_idx_q + 4'd1;
                     if (bit_idx_q == 4'd8) begin
                        uart_tx <= 1'b1;
                     end else begin
                        uart_tx <= shreg_q[0];
                        shreg_q <= {1'b0, shreg_q[31:1]};
                     end
                  end
               end
            end

            StNext: begin
               remaining_q  <= remaining_q - 11'd1;
               imem_rd_addr <= imem_rd_addr + 10'd1;
               if (abort_hit) begin
                  state_q <= StIdle;
                  busy    <= 1'b0;
                  abort_q <= 1'b0;
               end else if (remaining_q == 11'd1) begin
                  dump_done <= 1'b1;
                  busy      <= 1'b0;
                  state_q   <= StIdle;
               end else begin
                  imem_rd_en <= 1'b1;
                  state_q    <= StFetch;
               end
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: doc/imem_readback.md
IMEM_READBACK -- requirements
Module: imem_readback

Interface
REQ-001 Parameter BAUD_RATE, default 115200, UART bit rate.
REQ-002 Parameter CLK_FREQ, default 100_000_000, clk frequency in Hz.
REQ-003 Parameter IMEM_DEPTH, default 1024, instruction memory depth in 32-bit words.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin a dump.
REQ-007 abort  input  1  stop the dump at the next byte boundary.
REQ-008 start_addr  input  10  first word address to dump.
REQ-009 word_count  input  11  number of words to dump, 0..1024.
REQ-010 imem_rd_en  output  1  instruction memory read strobe.
REQ-011 imem_rd_addr  output  10  instruction memory read address.
REQ-012 imem_rd_data  input  32  read data, valid the cycle after imem_rd_en.
REQ-013 uart_tx  output  1  serial line, idles high.
REQ-014 busy  output  1  high from accepted start until return to IDLE.
REQ-015 dump_done  output  1  sticky; set on normal completion.
REQ-016 dump_error  output  1  sticky; set on a rejected range.

Function
REQ-017 CLKS_PER_BIT SHALL equal CLK_FREQ/BAUD_RATE (integer division); each line bit is held exactly CLKS_PER_BIT cycles.
REQ-018 Frame SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); there is no idle gap between consecutive bytes.
REQ-019 Each word SHALL be sent little-endian: imem_rd_data[7:0] first, [31:24] last.
REQ-020 The FSM SHALL have the states IDLE, FETCH, LATCH, SEND, NEXT.
REQ-021 IDLE: start=1 and abort=0 SHALL clear dump_done/dump_error; the block then checks the range.
REQ-022 If start_addr+word_count > IMEM_DEPTH (computed 12-bit, no wrap), it SHALL set dump_error the next cycle, send nothing, and stay in IDLE.
REQ-023 If word_count=0, it SHALL set dump_done the next cycle and send nothing.
REQ-024 Otherwise it SHALL load the address and remaining counters, set busy, and go to FETCH.
REQ-025 FETCH: imem_rd_en=1 for exactly one cycle, with imem_rd_addr = current address; then go to LATCH.
REQ-026 LATCH: capture imem_rd_data into a 32-bit shift register; uart_tx goes low (start bit) on the following cycle.
REQ-027 SEND: transmit 4 bytes back-to-back, then go to NEXT.
REQ-028 NEXT (1 cycle): decrement remaining and increment address; if remaining reaches 0, set dump_done, clear busy, and go to IDLE; otherwise go to FETCH.
REQ-029 Latency: start at edge N gives imem_rd_en high in cycle N+1 and the start bit beginning at cycle N+3.
REQ-030 Inter-word gap SHALL be exactly 3 cycles (NEXT, FETCH, LATCH) of uart_tx=1 after the stop bit.
REQ-031 start while busy SHALL be ignored.
REQ-032 Abort: abort is latched when seen while busy; the block returns to IDLE after the current stop bit completes, with dump_done not set.
REQ-033 A frame SHALL never be truncated by abort.
REQ-034 abort and start together in IDLE: abort wins and no dump starts.
REQ-035 imem_rd_en SHALL be 0 in every state except FETCH.
REQ-036 uart_tx SHALL be 1 outside SEND.

Reset
REQ-037 rst_n low SHALL asynchronously force: state IDLE, uart_tx=1, imem_rd_en=0, imem_rd_addr=0, busy=0, dump_done=0, dump_error=0, all counters and the shift register 0.
REQ-038 Reset mid-frame SHALL drive uart_tx high immediately; there is no resume after reset release.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000, CLKS_PER_BIT=10)
REQ-039 start_addr=0, word_count=1, mem[0]=0x12345678 -> bytes 78,56,34,12 on uart_tx, each bit 10 cycles; dump_done=1, busy=0.
REQ-040 start_addr=5, word_count=3 -> reads at addresses 5, 6, 7; 12 bytes sent; exactly 3 idle-high cycles between words.
REQ-041 start_addr=1020, word_count=5 -> dump_error=1 one cycle later, imem_rd_en never asserted, uart_tx stays 1; start_addr=1020, word_count=4 -> accepted.
REQ-042 word_count=0 -> dump_done=1 next cycle, no frames, busy stays 0.
REQ-043 abort during bit 3 of byte 1 of word 0 (word_count=4) -> byte 1 completes with its stop bit, then IDLE; dump_done=0; start pulses during busy have no effect.
REQ-044 rst_n low mid-byte -> uart_tx=1 and all outputs at reset values within the same cycle; a new start after release runs normally.
